alu_bist_checker: RTL and testbench
===================================

// Module: alu_bist_checker
// PURPOSE
//   Hardware self-test sequencer for the 8-bit 4-op ALU (00 AND, 01 XOR, 10 ADD, 11 SUB).
//   Drives A/B/opcode into the ALU, samples its result and compares it with an internal reference model.
//   Counts mismatches, captures the first failure and reports pass/fail.
//   Sits beside the ALU in the datapath as its on-chip stimulus/check end.
// PARAMETERS
//   NUM_VECTORS  256       operand pairs per run; each pair is applied with all 4 opcodes (>=1)
//   RESULT_LAT   0         extra cycles between driving operands and sampling alu_result (0..15)
//   SEED         16'hDAAA  LFSR seed; value 0 is replaced by 16'hACE1
// PORTS
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   1-cycle run request; honoured only in IDLE or DONE
//   alu_a       out  8   ALU operand A (registered)
//   alu_b       out  8   ALU operand B (registered)
//   alu_opcode  out  2   ALU opcode (registered)
//   alu_result  in   8   ALU result (combinational from alu_a/alu_b/alu_opcode)
//   busy        out  1   run in progress
//   done        out  1   run complete; held until next start or reset
//   pass        out  1   valid when done: 1 if err_cnt==0
//   err_cnt     out  16  mismatch count, saturates at 16'hFFFF
//   fail_a      out  8   A of first mismatch
//   fail_b      out  8   B of first mismatch
//   fail_op     out  2   opcode of first mismatch
//   fail_got    out  8   alu_result of first mismatch
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, all outputs 0, LFSR=SEED, vector count 0.
//   FSM: IDLE -> DRIVE -> [WAIT x RESULT_LAT] -> CHECK -> DRIVE ... -> DONE.
//   - IDLE/DONE + start:
//     - load LFSR=SEED, vec=0, err_cnt=0, fail_* = 0, done=0, pass=0;
//     - alu_a=SEED[15:8], alu_b=SEED[7:0], alu_opcode=00;
//     - go to DRIVE; busy=1.
//   - DRIVE: 1 cycle; go to WAIT if RESULT_LAT>0, else to CHECK.
//   - WAIT: RESULT_LAT cycles, then CHECK.
//   - CHECK: compare alu_result against ref(alu_a, alu_b, alu_opcode). All arithmetic is mod 256:
//     - ADD = (a+b)[7:0], carry dropped;
//     - SUB = (a-b)[7:0], two's-complement wrap.
//     On mismatch:
//     - err_cnt++ (saturating);
//     - when err_cnt was 0, capture fail_a/b/op/got.
//   - After CHECK:
//     - opcode<3: opcode++ -> DRIVE;
//     - opcode==3 and vec<NUM_VECTORS-1: LFSR steps once, vec++, alu_a/b = new LFSR[15:8]/[7:0], opcode=00 -> DRIVE;
//     - opcode==3 and vec==NUM_VECTORS-1: go to DONE, busy=0, done=1, pass=(final err_cnt==0).
//   - Timing: each check takes 2+RESULT_LAT cycles; a run takes 4*NUM_VECTORS*(2+RESULT_LAT) cycles after the start edge.
//   - start while busy: ignored. Operand outputs hold their values in DONE.
//   - LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0; steps only as stated above.
// STRUCTURE
//   alu_pkg: opcode enum (OP_AND, OP_XOR, OP_ADD, OP_SUB); alu_ref() function; state enum; LFSR_TAPS and ALT_SEED constants.
//   Sub-module lfsr16: clk, rst_n, load, seed, step -> q[15:0]. Everything else is inline.
// TESTING
//   1. NUM_VECTORS=1, RESULT_LAT=0, reference ALU, start:
//      - ALU sees DA/AA with ops 00,01,10,11, giving 8A, 70, 84, 30;
//      - done rises 8 clk after the start edge; pass=1; err_cnt=0.
//   2. Same config, alu_result tied to 8'h00:
//      - err_cnt=4, pass=0;
//      - fail_a=DA, fail_b=AA, fail_op=00, fail_got=00.
//   3. Same config, faulty ALU that keeps the carry wrong only for ADD (returns 8'h85):
//      - err_cnt=1, fail_op=10, fail_got=85.
//   4. NUM_VECTORS=256, RESULT_LAT=2, reference ALU with a 2-cycle registered output:
//      - done after 4096 cycles, pass=1;
//      - the LFSR sequence matches the bench model.
//   5. Reset asserted mid-run (vec=3), then released:
//      - all outputs return to 0 asynchronously; state IDLE;
//      - a new start reruns from SEED.
//   6. start pulsed during busy and again in DONE:
//      - the first is ignored (run length unchanged);
//      - the second clears done/err_cnt and restarts at vector DA/AA.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Purpose : Shared types and helpers for the ALU self-test sequencer:
//           ALU opcode encoding, golden ALU reference, sequencer state
//           encoding and the 16-bit Fibonacci LFSR polynomial/seed constants.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 with a left-shifting register: the taps
  // are the bits that become x^16, x^14, x^13 and x^11 after the shift.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // An all-zero seed would lock the LFSR, so it is swapped for this one.
  localparam logic [15:0] ALT_SEED  = 16'hACE1;

  // Golden model of the 8-bit ALU; sums and differences wrap modulo 256.
  function automatic logic [7:0] alu_ref(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input alu_op_e    op);
    logic [7:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] eff_seed(input logic [15:0] s);
    return (s == 16'h0000) ? ALT_SEED : s;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Purpose : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left
//           with the feedback bit entering bit 0. Load has priority over step.
// Ports   : clk     in   clock, rising edge
//           rst_n   in   asynchronous active-low reset (q <= RESET_SEED)
//           load_i  in   load seed_i
//           seed_i  in   16-bit seed value
//           step_i  in   advance one LFSR step
//           q_o     out  current LFSR state
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
  import alu_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        step_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_i;
    end else if (step_i) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/alu_bist_checker.sv
`default_nettype none
// ============================================================================
// Module  : alu_bist_checker
// Purpose : Self-test sequencer for the 8-bit 4-op ALU. For each of
//           NUM_VECTORS LFSR-generated operand pairs it applies all four
//           opcodes, waits RESULT_LAT extra cycles, compares alu_result_i
//           with the golden model, counts mismatches (saturating) and
//           records the first failing vector.
// Ports   : clk            in   clock, rising edge
//           rst_n          in   asynchronous active-low reset
//           start_i        in   run request, honoured only in IDLE/DONE
//           alu_a_o        out  operand A to the ALU (registered)
//           alu_b_o        out  operand B to the ALU (registered)
//           alu_opcode_o   out  opcode to the ALU (registered)
//           alu_result_i   in   ALU result
//           busy_o         out  run in progress
//           done_o         out  run complete, held until start/reset
//           pass_o         out  valid with done_o: no mismatch seen
//           err_cnt_o      out  mismatch count, saturating
//           fail_a_o/b_o   out  operands of the first mismatch
//           fail_op_o      out  opcode of the first mismatch
//           fail_got_o     out  ALU result of the first mismatch
// Revision: 1.0 - initial release
// ============================================================================
module alu_bist_checker
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter int          RESULT_LAT  = 0,
  parameter logic [15:0] SEED        = 16'hDAAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [1:0]  alu_opcode_o,
  input  logic [7:0]  alu_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [7:0]  fail_a_o,
  output logic [7:0]  fail_b_o,
  output logic [1:0]  fail_op_o,
  output logic [7:0]  fail_got_o
);

  localparam logic [15:0]   EFF_SEED  = eff_seed(SEED);
  localparam int            VW        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VW-1:0] LAST_VEC  = VW'(NUM_VECTORS - 1);
  // WAIT counts down to zero, so it is preloaded with one less than the latency.
  localparam logic [3:0]    WAIT_LOAD = (RESULT_LAT > 0) ? 4'(RESULT_LAT - 1) : 4'd0;

  bist_state_e   state_q;
  logic [VW-1:0] vec_q;
  logic [3:0]    wait_q;
  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  alu_op_e       op_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [15:0]   err_q;
  logic [7:0]    fail_a_q;
  logic [7:0]    fail_b_q;
  alu_op_e       fail_op_q;
  logic [7:0]    fail_got_q;

  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_nxt;
  logic          start_ok;
  logic          last_op;
  logic          last_vec;
  logic          lfsr_step;
  logic          mismatch;
  logic [15:0]   err_d;

  assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_op   = (op_q == OP_SUB);
  assign last_vec  = (vec_q == LAST_VEC);
  // The LFSR advances only when moving on to a fresh operand pair.
  assign lfsr_step = (state_q == ST_CHECK) && last_op && !last_vec;
  assign lfsr_nxt  = lfsr_next(lfsr_q);

  always_comb begin
    mismatch = (alu_result_i != alu_ref(alu_a_q, alu_b_q, op_q));
    err_d    = err_q;
    if (mismatch && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  lfsr16 #(
    .RESET_SEED (EFF_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .seed_i (EFF_SEED),
    .step_i (lfsr_step),
    .q_o    (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      wait_q     <= 4'd0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      op_q       <= OP_AND;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 16'h0000;
      fail_a_q   <= 8'h00;
      fail_b_q   <= 8'h00;
      fail_op_q  <= OP_AND;
      fail_got_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            vec_q      <= '0;
            err_q      <= 16'h0000;
            fail_a_q   <= 8'h00;
            fail_b_q   <= 8'h00;
            fail_op_q  <= OP_AND;
            fail_got_q <= 8'h00;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            alu_a_q    <= EFF_SEED[15:8];
            alu_b_q    <= EFF_SEED[7:0];
            op_q       <= OP_AND;
            state_q    <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (RESULT_LAT > 0) begin
            wait_q  <= WAIT_LOAD;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_CHECK;
          end
        end

        ST_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= ST_CHECK;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch && (err_q == 16'h0000)) begin
            fail_a_q   <= alu_a_q;
            fail_b_q   <= alu_b_q;
            fail_op_q  <= op_q;
            fail_got_q <= alu_result_i;
          end
          if (!last_op) begin
            op_q    <= alu_op_e'(op_q + 2'd1);
            state_q <= ST_DRIVE;
          end else if (!last_vec) begin
            vec_q   <= vec_q + VW'(1);
            alu_a_q <= lfsr_nxt[15:8];
            alu_b_q <= lfsr_nxt[7:0];
            op_q    <= OP_AND;
            state_q <= ST_DRIVE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // err_d already includes the verdict of this final check.
            pass_q  <= (err_d == 16'h0000);
            state_q <= ST_DONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = op_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_q;
  assign fail_a_o     = fail_a_q;
  assign fail_b_o     = fail_b_q;
  assign fail_op_o    = fail_op_q;
  assign fail_got_o   = fail_got_q;

endmodule : alu_bist_checker
`default_nettype wire

// File: tb/tb_alu_bist_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_bist_checker
// Purpose : Bench for alu_bist_checker. Instance 0 runs 1 vector with no
//           extra latency against a configurable (optionally faulty)
//           combinational ALU; instance 1 runs 256 vectors with a 2-cycle
//           registered ALU. A timing-based model predicts every output on
//           every cycle from the run rules; directed literal checks pin it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start [2];

  logic [7:0]  o_a    [2];
  logic [7:0]  o_b    [2];
  logic [1:0]  o_op   [2];
  logic [7:0]  res    [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_pass [2];
  logic [15:0] o_err  [2];
  logic [7:0]  o_fa   [2];
  logic [7:0]  o_fb   [2];
  logic [1:0]  o_fop  [2];
  logic [7:0]  o_fgot [2];

  // Environment ALU fault configuration per instance
  // mode: 0 clean, 1 stuck at 0, 2 ADD off by one, 3 xor on masked ops, 4 keyed xor
  int         cfg_mode [2];
  logic [3:0] cfg_mask [2];
  logic [7:0] cfg_x    [2];
  logic [3:0] cfg_key  [2];
  logic [1:0] cfg_kop  [2];

  int n_checks = 0;
  int n_err    = 0;

  localparam int NV  [2] = '{1, 256};
  localparam int PER [2] = '{2, 4};

  function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b, input int op);
    int r;
    case (op)
      0:       r = int'(a & b);
      1:       r = int'(a ^ b);
      2:       r = (int'(a) + int'(b)) % 256;
      default: r = (int'(a) - int'(b) + 256) % 256;
    endcase
    return 8'(r);
  endfunction

  function automatic logic [7:0] env_alu(input int mode, input logic [3:0] mask,
                                         input logic [7:0] x, input logic [3:0] key,
                                         input logic [1:0] kop, input logic [7:0] a,
                                         input logic [7:0] b, input logic [1:0] op);
    logic [7:0] g;
    g = golden(a, b, int'(op));
    case (mode)
      1:       return 8'h00;
      2:       return (op == 2'd2) ? g + 8'd1 : g;
      3:       return mask[op] ? (g ^ x) : g;
      4:       return ((a[3:0] == key) && (op == kop)) ? (g ^ x) : g;
      default: return g;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    // polynomial x^16+x^14+x^13+x^11+1: feedback from register stages 16,14,13,11
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic chk(input string name, input int d, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", name, d, got, exp, $time);
    end
  endtask

  assign res[0] = env_alu(cfg_mode[0], cfg_mask[0], cfg_x[0], cfg_key[0], cfg_kop[0],
                          o_a[0], o_b[0], o_op[0]);

  logic [7:0] alu2_s1, alu2_s2;
  always @(posedge clk) begin
    alu2_s1 <= env_alu(cfg_mode[1], cfg_mask[1], cfg_x[1], cfg_key[1], cfg_kop[1],
                       o_a[1], o_b[1], o_op[1]);
    alu2_s2 <= alu2_s1;
  end
  assign res[1] = alu2_s2;

  alu_bist_checker #(.NUM_VECTORS(1), .RESULT_LAT(0), .SEED(16'hDAAA)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]),
    .alu_a_o(o_a[0]), .alu_b_o(o_b[0]), .alu_opcode_o(o_op[0]), .alu_result_i(res[0]),
    .busy_o(o_busy[0]), .done_o(o_done[0]), .pass_o(o_pass[0]), .err_cnt_o(o_err[0]),
    .fail_a_o(o_fa[0]), .fail_b_o(o_fb[0]), .fail_op_o(o_fop[0]), .fail_got_o(o_fgot[0])
  );

  alu_bist_checker #(.NUM_VECTORS(256), .RESULT_LAT(2), .SEED(16'hDAAA)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]),
    .alu_a_o(o_a[1]), .alu_b_o(o_b[1]), .alu_opcode_o(o_op[1]), .alu_result_i(res[1]),
    .busy_o(o_busy[1]), .done_o(o_done[1]), .pass_o(o_pass[1]), .err_cnt_o(o_err[1]),
    .fail_a_o(o_fa[1]), .fail_b_o(o_fb[1]), .fail_op_o(o_fop[1]), .fail_got_o(o_fgot[1])
  );

  // Expected operand sequence
  logic [7:0] va [256];
  logic [7:0] vb [256];

  // Timing model: t = clock edges since the accepted start edge.
  bit         m_act  [2];
  int         m_t    [2];
  int         m_err  [2];
  logic [7:0] m_fa   [2];
  logic [7:0] m_fb   [2];
  int         m_fop  [2];
  logic [7:0] m_fgot [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 1'b0; m_t[d] = 0; m_err[d] = 0;
        m_fa[d] = 8'h00; m_fb[d] = 8'h00; m_fop[d] = 0; m_fgot[d] = 8'h00;
      end else begin
        int L, k;
        logic [7:0] a, b, got;
        L = 4 * NV[d] * PER[d];
        if (start[d] && !(m_act[d] && m_t[d] < L)) begin
          m_act[d] = 1'b1; m_t[d] = 0; m_err[d] = 0;
          m_fa[d] = 8'h00; m_fb[d] = 8'h00; m_fop[d] = 0; m_fgot[d] = 8'h00;
        end else if (m_act[d] && m_t[d] < L) begin
          m_t[d]++;
          if (m_t[d] % PER[d] == 0) begin
            k   = m_t[d] / PER[d] - 1;
            a   = va[k / 4];
            b   = vb[k / 4];
            got = env_alu(cfg_mode[d], cfg_mask[d], cfg_x[d], cfg_key[d], cfg_kop[d],
                          a, b, 2'(k % 4));
            if (got != golden(a, b, k % 4)) begin
              if (m_err[d] == 0) begin
                m_fa[d] = a; m_fb[d] = b; m_fop[d] = k % 4; m_fgot[d] = got;
              end
              if (m_err[d] < 65535) m_err[d]++;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int L, j;
      int ea, eb, eop, ebusy, edone, epass;
      L = 4 * NV[d] * PER[d];
      if (!m_act[d]) begin
        ea = 0; eb = 0; eop = 0; ebusy = 0; edone = 0; epass = 0;
      end else begin
        j     = (m_t[d] < L) ? m_t[d] / PER[d] : 4 * NV[d] - 1;
        ea    = int'(va[j / 4]);
        eb    = int'(vb[j / 4]);
        eop   = j % 4;
        ebusy = (m_t[d] < L) ? 1 : 0;
        edone = (m_t[d] >= L) ? 1 : 0;
        epass = (edone == 1 && m_err[d] == 0) ? 1 : 0;
      end
      chk("alu_a",    d, int'(o_a[d]),    ea);
      chk("alu_b",    d, int'(o_b[d]),    eb);
      chk("alu_op",   d, int'(o_op[d]),   eop);
      chk("busy",     d, int'(o_busy[d]), ebusy);
      chk("done",     d, int'(o_done[d]), edone);
      chk("pass",     d, int'(o_pass[d]), epass);
      chk("err_cnt",  d, int'(o_err[d]),  m_err[d]);
      chk("fail_a",   d, int'(o_fa[d]),   int'(m_fa[d]));
      chk("fail_b",   d, int'(o_fb[d]),   int'(m_fb[d]));
      chk("fail_op",  d, int'(o_fop[d]),  m_fop[d]);
      chk("fail_got", d, int'(o_fgot[d]), int'(m_fgot[d]));
    end
  end

  // Pulse start for instance d, return edges from the start edge until done.
  // An optional second start pulse lands while the run is busy.
  task automatic run_dut(input int d, input int busy_pulse_at, output int cyc);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk("start_a", d, int'(o_a[d]), 8'hDA);
    chk("start_b", d, int'(o_b[d]), 8'hAA);
    cyc = 0;
    while (cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      start[d] = (cyc == busy_pulse_at);
      if (o_done[d]) break;
    end
    start[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    logic [15:0] s;
    int cyc, exp_cnt;
    logic [7:0] pa, pb;

    s = 16'hDAAA;
    for (int j = 0; j < 256; j++) begin
      va[j] = s[15:8];
      vb[j] = s[7:0];
      s = lfsr_model(s);
    end

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; cfg_mode[d] = 0; cfg_mask[d] = 4'h0;
      cfg_x[d] = 8'h00; cfg_key[d] = 4'h0; cfg_kop[d] = 2'd0;
    end

    // Pin the model with hand-computed values
    pa = va[0]; pb = vb[0];
    chk("model_a0", 0, int'(pa), 8'hDA);
    chk("model_b0", 0, int'(pb), 8'hAA);
    chk("model_a1", 0, int'(va[1]), 8'hB5);
    chk("model_b1", 0, int'(vb[1]), 8'h54);
    chk("model_and", 0, int'(golden(pa, pb, 0)), 8'h8A);
    chk("model_xor", 0, int'(golden(pa, pb, 1)), 8'h70);
    chk("model_add", 0, int'(golden(pa, pb, 2)), 8'h84);
    chk("model_sub", 0, int'(golden(pa, pb, 3)), 8'h30);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 0, int'(o_busy[0]), 0);
    chk("rst_err",  1, int'(o_err[1]),  0);

    // Clean single-vector run
    run_dut(0, -1, cyc);
    chk("len_clean", 0, cyc, 8);
    chk("pass_clean", 0, int'(o_pass[0]), 1);
    chk("err_clean", 0, int'(o_err[0]), 0);

    // ALU stuck at zero
    cfg_mode[0] = 1;
    run_dut(0, -1, cyc);
    chk("err_zero", 0, int'(o_err[0]), 4);
    chk("pass_zero", 0, int'(o_pass[0]), 0);
    chk("fa_zero", 0, int'(o_fa[0]), 8'hDA);
    chk("fb_zero", 0, int'(o_fb[0]), 8'hAA);
    chk("fop_zero", 0, int'(o_fop[0]), 0);
    chk("fgot_zero", 0, int'(o_fgot[0]), 8'h00);

    // ADD with wrong carry handling
    cfg_mode[0] = 2;
    run_dut(0, -1, cyc);
    chk("err_add", 0, int'(o_err[0]), 1);
    chk("fop_add", 0, int'(o_fop[0]), 2);
    chk("fgot_add", 0, int'(o_fgot[0]), 8'h85);

    // Start ignored while busy; restart from DONE clears previous errors
    cfg_mode[0] = 0;
    run_dut(0, 3, cyc);
    chk("len_busy_start", 0, cyc, 8);
    chk("err_restart", 0, int'(o_err[0]), 0);

    // Randomized fault patterns on the short instance
    for (int it = 0; it < 10; it++) begin
      cfg_mode[0] = 3;
      cfg_mask[0] = 4'($urandom_range(0, 15));
      cfg_x[0]    = 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_dut(0, int'($urandom_range(1, 6)), cyc);
      exp_cnt = 0;
      for (int k = 0; k < 4; k++) if (cfg_mask[0][k]) exp_cnt++;
      chk("len_rand", 0, cyc, 8);
      chk("err_rand", 0, int'(o_err[0]), exp_cnt);
    end

    // Full 256-vector run with a 2-cycle registered ALU
    run_dut(1, 100, cyc);
    chk("len_full", 1, cyc, 4096);
    chk("pass_full", 1, int'(o_pass[1]), 1);
    chk("last_a", 1, int'(o_a[1]), int'(va[255]));

    // Keyed random fault on one opcode
    cfg_mode[1] = 4;
    cfg_key[1]  = 4'($urandom_range(0, 15));
    cfg_kop[1]  = 2'($urandom_range(0, 3));
    cfg_x[1]    = 8'($urandom_range(1, 255));
    run_dut(1, -1, cyc);
    exp_cnt = 0;
    for (int v = 0; v < 256; v++) if (va[v][3:0] == cfg_key[1]) exp_cnt++;
    chk("len_keyed", 1, cyc, 4096);
    chk("err_keyed", 1, int'(o_err[1]), exp_cnt);
    chk("pass_keyed", 1, int'(o_pass[1]), (exp_cnt == 0) ? 1 : 0);

    // Reset in the middle of vector 3, then rerun from the seed
    cfg_mode[1] = 0;
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (3 * 16 + 5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a", 1, int'(o_a[1]), 0);
    chk("async_busy", 1, int'(o_busy[1]), 0);
    chk("async_op", 1, int'(o_op[1]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_dut(1, -1, cyc);
    chk("len_after_rst", 1, cyc, 4096);
    chk("pass_after_rst", 1, int'(o_pass[1]), 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_alu_bist_checker
`default_nettype wire
